vga_timing_controller: RTL and testbench

Generates VGA raster timing for a single pixel clock: horizontal/vertical counters, sync pulses, display-enable and pixel coordinates. Sits directly upstream of the image generator and feeds its `disp_ena`, `row` and `column` inputs. Its `h_sync`/`v_sync` drive the board VGA connector. Default configuration is 640x480 at 60 Hz with a 25 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 44 ++++
 rtl/vga_timing_controller.sv | 90 +++++++++
 tb/tb_vga_timing_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing controller and image generator.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_PULSE  = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_PIXELS = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_PULSE  = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int axis_total(input int vis, input int fp, input int pulse, input int bp);
        return vis + fp + pulse + bp;
    endfunction

    function automatic int h_total(input int pixels, input int fp, input int pulse, input int bp);
        return axis_total(pixels, fp, pulse, bp);
    endfunction

    function automatic int v_total(input int lines, input int fp, input int pulse, input int bp);
        return axis_total(lines, fp, pulse, bp);
    endfunction

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running 0..TOTAL-1 counter with visible/sync decode of the current count.
// Latency: count updates on the clock after adv_en; wrap/visible/sync_active are combinational from count.
// Backpressure: none; advances whenever adv_en is high.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEF_H_PIXELS,
    parameter int FP      = DEF_H_FP,
    parameter int PULSE   = DEF_H_PULSE,
    parameter int BP      = DEF_H_BP,
    localparam int TOTAL  = axis_total(VISIBLE, FP, PULSE, BP),
    localparam int CW     = cnt_width(TOTAL)
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          adv_en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          visible,
    output logic          sync_active
);

    if (VISIBLE < 0 || FP < 1 || PULSE < 1 || BP < 1 || TOTAL < 1) begin : g_bad_params
        $error("vga_axis_counter: porch and pulse widths must be >= 1 and totals > 0");
    end

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS_END    = CW'(VISIBLE);
    localparam logic [CW-1:0] SYNC_START = CW'(VISIBLE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(VISIBLE + FP + PULSE);

    assign wrap        = adv_en && (count == LAST);
    assign visible     = (count < VIS_END);
    assign sync_active = (count >= SYNC_START) && (count < SYNC_END);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (adv_en) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: h/v counters, sync pulses, display enable, pixel coordinates and frame start.
// Latency: every output is the registered decode of the counter state one clock earlier.
// Backpressure: none; free-running, no stall input.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_PULSE  = DEF_H_PULSE,
    parameter int H_BP     = DEF_H_BP,
    parameter bit H_POL    = SYNC_ACTIVE_LOW,
    parameter int V_PIXELS = DEF_V_PIXELS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_PULSE  = DEF_V_PULSE,
    parameter int V_BP     = DEF_V_BP,
    parameter bit V_POL    = SYNC_ACTIVE_LOW
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    output logic        h_sync,
    output logic        v_sync,
    output logic        disp_ena,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        frame_start
);

    localparam int H_CW = cnt_width(h_total(H_PIXELS, H_FP, H_PULSE, H_BP));
    localparam int V_CW = cnt_width(v_total(V_PIXELS, V_FP, V_PULSE, V_BP));

    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic            h_wrap, h_vis, h_act;
    logic            v_wrap, v_vis, v_act;
    logic            origin_q;

    vga_axis_counter #(
        .VISIBLE (H_PIXELS),
        .FP      (H_FP),
        .PULSE   (H_PULSE),
        .BP      (H_BP)
    ) u_h_axis (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .adv_en      (1'b1),
        .count       (h_cnt),
        .wrap        (h_wrap),
        .visible     (h_vis),
        .sync_active (h_act)
    );

    vga_axis_counter #(
        .VISIBLE (V_PIXELS),
        .FP      (V_FP),
        .PULSE   (V_PULSE),
        .BP      (V_BP)
    ) u_v_axis (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .adv_en      (h_wrap),
        .count       (v_cnt),
        .wrap        (v_wrap),
        .visible     (v_vis),
        .sync_active (v_act)
    );

    // origin_q is high exactly while the counters sit at (0,0): set by reset and by the frame wrap.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            origin_q    <= 1'b1;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            disp_ena    <= 1'b0;
            frame_start <= 1'b0;
            column      <= '0;
            row         <= '0;
        end else begin
            origin_q    <= v_wrap;
            h_sync      <= h_act ? H_POL : ~H_POL;
            v_sync      <= v_act ? V_POL : ~V_POL;
            disp_ena    <= h_vis && v_vis;
            frame_start <= origin_q;
            if (h_vis && v_vis) begin
                column <= 32'(h_cnt);
                row    <= 32'(v_cnt);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench: default 640x480 instance plus a tiny active-high instance (14x7 raster).
// Expected outputs are pushed with their sample tick; a negedge monitor pops and compares.
module tb_vga_timing_controller;

    logic        clk = 1'b0;
    logic        rst_a_n = 1'b0;
    logic        rst_b_n = 1'b0;

    logic        a_hs, a_vs, a_de, a_fs;
    logic [31:0] a_col, a_row;
    logic        b_hs, b_vs, b_de, b_fs;
    logic [31:0] b_col, b_row;

    int unsigned tick = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    typedef struct {
        int unsigned t;
        bit          sel;
        string       tag;
        int          k;
        logic        hs, vs, de, fs;
        logic [31:0] col, row;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic        act_hs, act_vs, act_de, act_fs;
    logic [31:0] act_col, act_row;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    vga_timing_controller dut_a (
        .pixel_clk   (clk),
        .reset_n     (rst_a_n),
        .h_sync      (a_hs),
        .v_sync      (a_vs),
        .disp_ena    (a_de),
        .column      (a_col),
        .row         (a_row),
        .frame_start (a_fs)
    );

    vga_timing_controller #(
        .H_PIXELS (8), .H_FP (2), .H_PULSE (2), .H_BP (2), .H_POL (1'b1),
        .V_PIXELS (4), .V_FP (1), .V_PULSE (1), .V_BP (1), .V_POL (1'b1)
    ) dut_b (
        .pixel_clk   (clk),
        .reset_n     (rst_b_n),
        .h_sync      (b_hs),
        .v_sync      (b_vs),
        .disp_ena    (b_de),
        .column      (b_col),
        .row         (b_row),
        .frame_start (b_fs)
    );

    task automatic push(input int unsigned t, input bit sel, input string tag, input int k,
                        input logic hs, input logic vs, input logic de, input logic fs,
                        input int col, input int row);
        exp_t e;
        e.t = t; e.sel = sel; e.tag = tag; e.k = k;
        e.hs = hs; e.vs = vs; e.de = de; e.fs = fs;
        e.col = 32'(col); e.row = 32'(row);
        sb_q.push_back(e);
    endtask

    task automatic wait_tick(input int unsigned t);
        while (tick < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].t <= tick) begin
            mon_e = sb_q.pop_front();
            if (mon_e.sel) begin
                act_hs = b_hs; act_vs = b_vs; act_de = b_de; act_fs = b_fs;
                act_col = b_col; act_row = b_row;
            end else begin
                act_hs = a_hs; act_vs = a_vs; act_de = a_de; act_fs = a_fs;
                act_col = a_col; act_row = a_row;
            end
            tests_run = tests_run + 1;
            if (mon_e.t != tick) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s k=%0d: sample missed, due tick %0d, now tick %0d",
                         mon_e.tag, mon_e.k, mon_e.t, tick);
            end else if (act_hs !== mon_e.hs || act_vs !== mon_e.vs || act_de !== mon_e.de ||
                         act_fs !== mon_e.fs || act_col !== mon_e.col || act_row !== mon_e.row) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s k=%0d: got hs=%b vs=%b de=%b fs=%b col=%0d row=%0d, want hs=%b vs=%b de=%b fs=%b col=%0d row=%0d",
                         mon_e.tag, mon_e.k, act_hs, act_vs, act_de, act_fs, act_col, act_row,
                         mon_e.hs, mon_e.vs, mon_e.de, mon_e.fs, mon_e.col, mon_e.row);
            end
        end
    end

    initial begin
        int unsigned base;

        // Power-on reset, 5 clocks: default idles high, active-high instance idles low.
        for (int i = 1; i <= 5; i++) begin
            push(i, 1'b0, "a_reset", i, 1, 1, 0, 0, 0, 0);
            push(i, 1'b1, "b_reset", i, 0, 0, 0, 0, 0, 0);
        end
        wait_tick(5);
        #1 rst_a_n = 1'b1;
        base = tick + 1;

        // Default line timing: k = clocks since release, h = k%800, v = k/800.
        push(base + 0,    0, "a_origin",    0,    1, 1, 1, 1, 0,   0);
        push(base + 1,    0, "a_col1",      1,    1, 1, 1, 0, 1,   0);
        push(base + 639,  0, "a_last_vis",  639,  1, 1, 1, 0, 639, 0);
        push(base + 640,  0, "a_de_fall",   640,  1, 1, 0, 0, 639, 0);
        push(base + 655,  0, "a_fp_end",    655,  1, 1, 0, 0, 639, 0);
        push(base + 656,  0, "a_hs_start",  656,  0, 1, 0, 0, 639, 0);
        push(base + 751,  0, "a_hs_last",   751,  0, 1, 0, 0, 639, 0);
        push(base + 752,  0, "a_hs_end",    752,  1, 1, 0, 0, 639, 0);
        push(base + 799,  0, "a_line_end",  799,  1, 1, 0, 0, 639, 0);
        push(base + 800,  0, "a_line1",     800,  1, 1, 1, 0, 0,   1);
        push(base + 1599, 0, "a_line1_end", 1599, 1, 1, 0, 0, 639, 1);
        push(base + 1605, 0, "a_l2_c5",     1605, 1, 1, 1, 0, 5,   2);
        push(base + 1900, 0, "a_l2_c300",   1900, 1, 1, 1, 0, 300, 2);
        for (int i = 1; i <= 3; i++)
            push(base + 1900 + i, 0, "a_mid_reset", i, 1, 1, 0, 0, 0, 0);

        wait_tick(base + 1900);
        #1 rst_a_n = 1'b0;
        wait_tick(base + 1903);
        #1 rst_a_n = 1'b1;
        base = tick + 1;
        push(base + 0,   0, "a_restart",    0,   1, 1, 1, 1, 0,   0);
        push(base + 1,   0, "a_restart_c1", 1,   1, 1, 1, 0, 1,   0);
        push(base + 640, 0, "a_restart_bl", 640, 1, 1, 0, 0, 639, 0);
        push(base + 800, 0, "a_restart_l1", 800, 1, 1, 1, 0, 0,   1);

        // Small raster: H_TOTAL=14, V_TOTAL=7, frame=98, syncs active-high.
        wait_tick(base + 801);
        #1 rst_b_n = 1'b1;
        base = tick + 1;
        push(base + 0,   1, "b_origin",   0,   0, 0, 1, 1, 0, 0);
        push(base + 1,   1, "b_col1",     1,   0, 0, 1, 0, 1, 0);
        push(base + 7,   1, "b_last_vis", 7,   0, 0, 1, 0, 7, 0);
        push(base + 8,   1, "b_de_fall",  8,   0, 0, 0, 0, 7, 0);
        push(base + 9,   1, "b_fp",       9,   0, 0, 0, 0, 7, 0);
        push(base + 10,  1, "b_hs_start", 10,  1, 0, 0, 0, 7, 0);
        push(base + 11,  1, "b_hs_last",  11,  1, 0, 0, 0, 7, 0);
        push(base + 12,  1, "b_hs_end",   12,  0, 0, 0, 0, 7, 0);
        push(base + 13,  1, "b_line_end", 13,  0, 0, 0, 0, 7, 0);
        push(base + 14,  1, "b_line1",    14,  0, 0, 1, 0, 0, 1);
        push(base + 49,  1, "b_last_px",  49,  0, 0, 1, 0, 7, 3);
        push(base + 56,  1, "b_vblank",   56,  0, 0, 0, 0, 7, 3);
        push(base + 69,  1, "b_pre_vs",   69,  0, 0, 0, 0, 7, 3);
        push(base + 70,  1, "b_vs_start", 70,  0, 1, 0, 0, 7, 3);
        push(base + 80,  1, "b_vs_hs",    80,  1, 1, 0, 0, 7, 3);
        push(base + 83,  1, "b_vs_last",  83,  0, 1, 0, 0, 7, 3);
        push(base + 84,  1, "b_vs_end",   84,  0, 0, 0, 0, 7, 3);
        push(base + 97,  1, "b_frame_end",97,  0, 0, 0, 0, 7, 3);
        push(base + 98,  1, "b_frame2",   98,  0, 0, 1, 1, 0, 0);
        push(base + 99,  1, "b_frame2_c1",99,  0, 0, 1, 0, 1, 0);
        push(base + 196, 1, "b_frame3",   196, 0, 0, 1, 1, 0, 0);
        push(base + 227, 1, "b_l2_c3",    227, 0, 0, 1, 0, 3, 2);
        for (int i = 1; i <= 3; i++)
            push(base + 227 + i, 1, "b_mid_reset", i, 0, 0, 0, 0, 0, 0);

        wait_tick(base + 227);
        #1 rst_b_n = 1'b0;
        wait_tick(base + 230);
        #1 rst_b_n = 1'b1;
        base = tick + 1;
        push(base + 0,  1, "b_restart",    0,  0, 0, 1, 1, 0, 0);
        push(base + 1,  1, "b_restart_c1", 1,  0, 0, 1, 0, 1, 0);
        push(base + 14, 1, "b_restart_l1", 14, 0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            tests_run = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL drain: %0d expected samples never compared, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
